// File: rtl/ddrctl1_issuer.sv
// ddrctl1_issuer
// Host-side initiator for the DdrCtl1 instruction port. Each 32-bit read or
// write request, taken on a valid/ready handshake, becomes a DdrCtl1
// instruction stream: address loads (LA0..LA3), data loads for writes
// (LD0..LD3), then WRP or RDP. The block then waits for the controller's
// ready and returns one response pulse, with read data or a timeout flag.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write page, 0 = read page
//   req_addr, req_data    page address and write data (byte k -> LAk / LDk)
//   rsp_valid             one-cycle completion pulse
//   rsp_data, rsp_error   read data (0 for writes/errors), timeout flag
//   inst, inst_en         {opcode, imm} instruction to DdrCtl1 and its strobe
//   ctl_page, ctl_ready   DdrCtl1 page output and ready
module ddrctl1_issuer #(
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 4096,
   parameter int SKIP_LA = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_error,
   output logic [11:0] inst,
   output logic        inst_en,
   input  logic [31:0] ctl_page,
   input  logic        ctl_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

   localparam logic [3:0] OP_LA0 = 4'h1;
   localparam logic [3:0] OP_LD0 = 4'h5;
   localparam logic [3:0] OP_RDP = 4'h9;
   localparam logic [3:0] OP_WRP = 4'hA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_D,
      S_ISSUE,
      S_GUARD,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   logic [1:0]      idx;
   logic            lat_write;
   logic [31:0]     lat_addr;
   logic [31:0]     lat_data;
   logic [31:0]     last_addr;
   logic            addr_cached;
   logic [GW-1:0]   guard_cnt;
   logic [CW-1:0]   wait_cnt;
   logic            skip_hit;

   // The controller keeps its address registers between commands, so the
   // LA loads can be dropped when the same page was the last one reached.
   assign skip_hit = (SKIP_LA != 0) && addr_cached && (req_addr == last_addr);

   function automatic logic [11:0] la_inst(input logic [1:0] k, input logic [31:0] a);
      return {OP_LA0 + {2'b00, k}, a[{k, 3'b000} +: 8]};
   endfunction

   function automatic logic [11:0] ld_inst(input logic [1:0] k, input logic [31:0] d);
      return {OP_LD0 + {2'b00, k}, d[{k, 3'b000} +: 8]};
   endfunction

   // Sequencer. Every output is a register loaded with the value it must
   // show in the state being entered, so inst appears the cycle after the
   // edge that moves into LOAD_A/LOAD_D/ISSUE. The wait counter is
   // pre-loaded to 1 so that a timeout response lands exactly
   // GUARD+TIMEOUT cycles after the ISSUE cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= 2'd0;
         lat_write   <= 1'b0;
         lat_addr    <= '0;
         lat_data    <= '0;
         last_addr   <= '0;
         addr_cached <= 1'b0;
         guard_cnt   <= '0;
         wait_cnt    <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         inst        <= '0;
         inst_en     <= 1'b0;
      end else begin
         inst_en   <= 1'b0;
         inst      <= '0;
         rsp_valid <= 1'b0;
         req_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               req_ready <= ctl_ready;
               if (req_valid && req_ready) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_data  <= req_data;
                  req_ready <= 1'b0;
                  idx       <= 2'd0;
                  inst_en   <= 1'b1;
                  if (!skip_hit) begin
                     state <= S_LOAD_A;
                     inst  <= la_inst(2'd0, req_addr);
                  end else if (req_write) begin
                     state <= S_LOAD_D;
                     inst  <= ld_inst(2'd0, req_data);
                  end else begin
                     state <= S_ISSUE;
                     inst  <= {OP_RDP, 8'h00};
                  end
               end
            end
            S_LOAD_A: begin
               inst_en <= 1'b1;
               if (idx == 2'd3) begin
                  idx <= 2'd0;
                  if (lat_write) begin
                     state <= S_LOAD_D;
                     inst  <= ld_inst(2'd0, lat_data);
                  end else begin
                     state <= S_ISSUE;
                     inst  <= {OP_RDP, 8'h00};
                  end
               end else begin
                  idx  <= idx + 2'd1;
                  inst <= la_inst(idx + 2'd1, lat_addr);
               end
            end
            S_LOAD_D: begin
               inst_en <= 1'b1;
               if (idx == 2'd3) begin
                  idx   <= 2'd0;
                  state <= S_ISSUE;
                  inst  <= {OP_WRP, 8'h00};
               end else begin
                  idx  <= idx + 2'd1;
                  inst <= ld_inst(idx + 2'd1, lat_data);
               end
            end
            S_ISSUE: begin
               guard_cnt <= '0;
               wait_cnt  <= CW'(1);
               state     <= (GUARD == 0) ? S_WAIT : S_GUARD;
            end
            // The controller needs a couple of cycles to pull ready low
            // after a page command, so ready is not trusted here.
            S_GUARD: begin
               if (guard_cnt == GW'(GUARD - 1)) begin
                  state <= S_WAIT;
               end else begin
                  guard_cnt <= guard_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (ctl_ready) begin
                  state       <= S_RESP;
                  rsp_valid   <= 1'b1;
                  rsp_error   <= 1'b0;
                  rsp_data    <= lat_write ? 32'h0 : ctl_page;
                  last_addr   <= lat_addr;
                  addr_cached <= 1'b1;
               end else if (wait_cnt >= CW'(TIMEOUT - 1)) begin
                  state       <= S_RESP;
                  rsp_valid   <= 1'b1;
                  rsp_error   <= 1'b1;
                  rsp_data    <= 32'h0;
                  addr_cached <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddrctl1_issuer.sv
// tb_ddrctl1_issuer
// Self-checking bench for ddrctl1_issuer. A request-level reference model
// (cached address, page contents) predicts the instruction stream and the
// response of every request; a small DdrCtl1 model decodes the issued
// instructions, stores written pages and drives ctl_ready/ctl_page.
module tb_ddrctl1_issuer;

   localparam int GUARD   = 2;
   localparam int TIMEOUT = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic [11:0] inst;
   logic        inst_en;
   logic [31:0] ctl_page = '0;
   logic        ctl_ready = 1'b0;

   always #5 clock = ~clock;

   ddrctl1_issuer #(.GUARD(GUARD), .TIMEOUT(TIMEOUT), .SKIP_LA(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_error (rsp_error),
      .inst      (inst),
      .inst_en   (inst_en),
      .ctl_page  (ctl_page),
      .ctl_ready (ctl_ready)
   );

   int compared   = 0;
   int mismatched = 0;

   // request-level reference model
   bit          ref_cached = 1'b0;
   logic [31:0] ref_last   = '0;
   logic [31:0] ref_mem [logic [31:0]];
   logic [11:0] exp_q [$];

   // DdrCtl1 behavioural model
   logic [7:0]  cm_addr [4];
   logic [7:0]  cm_data [4];
   logic [31:0] cm_mem [logic [31:0]];
   int          cur_hold  = 1;
   int          hold_left = 0;
   bit          pend_read = 1'b0;

   // monitor state
   logic [11:0] capture [$];
   int          cycle = 0;
   int          issue_cycle = 0;
   int          rsp_cycle = 0;
   int          rsp_count = 0;
   int          first_inst_cycle = 0;
   logic [31:0] rsp_data_seen = '0;
   logic        rsp_error_seen = 1'b0;

   // Single comparison point: counts and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Expected instruction stream from the request rules alone.
   function automatic void build_expected(input bit wr, input logic [31:0] a,
                                          input logic [31:0] d);
      exp_q.delete();
      if (!(ref_cached && a == ref_last)) begin
         for (int k = 0; k < 4; k++) exp_q.push_back({4'(1 + k), a[8*k +: 8]});
      end
      if (wr) begin
         for (int k = 0; k < 4; k++) exp_q.push_back({4'(5 + k), d[8*k +: 8]});
      end
      exp_q.push_back({wr ? 4'hA : 4'h9, 8'h00});
   endfunction

   // One cycle: sample at the falling edge, run monitor and controller model.
   task automatic tick();
      logic [3:0]  op;
      logic [31:0] a;
      @(negedge clock);
      cycle++;
      if (rsp_valid) begin
         rsp_count++;
         rsp_cycle      = cycle;
         rsp_data_seen  = rsp_data;
         rsp_error_seen = rsp_error;
      end
      a = {cm_addr[3], cm_addr[2], cm_addr[1], cm_addr[0]};
      if (inst_en) begin
         if (capture.size() == 0) first_inst_cycle = cycle;
         capture.push_back(inst);
         op = inst[11:8];
         if (op >= 4'h1 && op <= 4'h4) begin
            cm_addr[int'(op) - 1] = inst[7:0];
         end else if (op >= 4'h5 && op <= 4'h8) begin
            cm_data[int'(op) - 5] = inst[7:0];
         end else if (op == 4'h9 || op == 4'hA) begin
            if (op == 4'hA) cm_mem[a] = {cm_data[3], cm_data[2], cm_data[1], cm_data[0]};
            pend_read   = (op == 4'h9);
            issue_cycle = cycle;
            ctl_ready   = 1'b0;
            hold_left   = cur_hold;
         end
      end else if (hold_left > 0) begin
         hold_left--;
         if (hold_left == 0) begin
            ctl_ready = 1'b1;
            if (pend_read) ctl_page = cm_mem.exists(a) ? cm_mem[a] : 32'h0;
            else           ctl_page = $urandom;
         end
      end
   endtask

   // Drive one request end to end and check stream and response.
   // hold < 0 keeps the controller busy forever (timeout case).
   task automatic applyStimulus(input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input int hold);
      int          n;
      bit          exp_err;
      logic [31:0] exp_data;
      build_expected(wr, a, d);
      exp_err  = (hold < 0);
      exp_data = (exp_err || wr) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
      cur_hold  = hold;
      req_write = wr;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 1000) begin
         tick();
         n++;
      end
      if (!req_ready) begin
         checkOutput("accept_wait", 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      capture.delete();
      rsp_count = 0;
      tick();
      req_valid = 1'b0;
      checkOutput("first_inst_en", 32'(inst_en), 32'h1);
      n = 0;
      while (rsp_count == 0 && n < TIMEOUT + GUARD + 100) begin
         tick();
         n++;
      end
      checkOutput("rsp_seen", 32'(rsp_count), 32'h1);
      repeat (3) tick();
      checkOutput("rsp_pulses", 32'(rsp_count), 32'h1);
      checkOutput("inst_count", 32'(capture.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < capture.size(); i++)
         checkOutput($sformatf("inst%0d", i), 32'(capture[i]), 32'(exp_q[i]));
      checkOutput("rsp_error", 32'(rsp_error_seen), 32'(exp_err));
      checkOutput("rsp_data", rsp_data_seen, exp_data);
      checkOutput("rsp_hold", rsp_data, exp_data);
      if (exp_err) begin
         checkOutput("timeout_latency", 32'(rsp_cycle - issue_cycle), 32'(GUARD + TIMEOUT));
         ctl_ready = 1'b1;
         ref_cached = 1'b0;
      end else begin
         ref_cached = 1'b1;
         ref_last   = a;
         if (wr) ref_mem[a] = d;
      end
   endtask

   initial begin
      int          rise_cycle;
      int          n;
      bit          saw_ready;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] pool [3];

      for (int k = 0; k < 4; k++) begin
         cm_addr[k] = 8'h00;
         cm_data[k] = 8'h00;
      end

      // reset values
      #1;
      checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
      checkOutput("reset_inst_en", 32'(inst_en), 32'h0);
      checkOutput("reset_inst", 32'(inst), 32'h0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("reset_rsp_error", 32'(rsp_error), 32'h0);
      checkOutput("reset_rsp_data", rsp_data, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // power-up: controller not ready, request held
      req_write = 1'b1;
      req_addr  = 32'h002B3F12;
      req_data  = 32'hDDCCBBAA;
      req_valid = 1'b1;
      saw_ready = 1'b0;
      repeat (100) begin
         tick();
         if (req_ready) saw_ready = 1'b1;
      end
      checkOutput("powerup_ready_low", 32'(saw_ready), 32'h0);
      ctl_ready  = 1'b1;
      rise_cycle = cycle;
      applyStimulus(1'b1, 32'h002B3F12, 32'hDDCCBBAA, 30);
      checkOutput("powerup_accept_delay", 32'(first_inst_cycle - rise_cycle), 32'h2);

      // read same page: address loads skipped
      applyStimulus(1'b0, 32'h002B3F12, 32'h0, 12);
      // read a different page: full address reload
      applyStimulus(1'b0, 32'h012B3F12, 32'h0, 7);
      // timeout, then the same address must reload LA0..LA3
      applyStimulus(1'b0, 32'h012B3F12, 32'h0, -1);
      applyStimulus(1'b0, 32'h012B3F12, 32'h0, 5);

      // reset during the LD1 cycle of a write
      a = 32'hCAFE0042;
      d = 32'h11223344;
      cur_hold  = 10;
      req_write = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 1000) begin
         tick();
         n++;
      end
      capture.delete();
      rsp_count = 0;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (capture.size() < 6 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("ld1_reached", 32'(capture.size()), 32'd6);
      if (capture.size() >= 6) checkOutput("ld1_inst", 32'(capture[5]), 32'h633);
      reset = 1'b0;
      #1;
      checkOutput("abort_inst_en", 32'(inst_en), 32'h0);
      checkOutput("abort_inst", 32'(inst), 32'h0);
      tick();
      reset = 1'b1;
      repeat (10) tick();
      checkOutput("abort_no_rsp", 32'(rsp_count), 32'h0);
      ref_cached = 1'b0;
      applyStimulus(1'b1, a, 32'h55667788, 9);
      applyStimulus(1'b0, a, 32'h0, 4);

      // randomized traffic over a small address pool to exercise skipping
      pool[0] = 32'h00001000;
      pool[1] = 32'h002B3F12;
      pool[2] = $urandom;
      repeat (30) begin
         applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 2)],
                       $urandom, int'($urandom_range(1, 40)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ddrctl1_issuer.md
Name: ddrctl1_issuer

Overview:
Host-side initiator for the DdrCtl1 instruction port. It accepts 32-bit word read/write requests on a valid/ready handshake and expands each into the DdrCtl1 12-bit instruction stream: address loads, data loads, then WRP or RDP. It waits for the controller's ready, returns read data taken from the controller's page output, and reports timeouts. It sits between user logic and DdrCtl1 and replaces hand-driven instruction sequences.

Parameters:
GUARD, 2, cycles after WRP/RDP issue during which ctl_ready is ignored (controller drop latency)
TIMEOUT, 4096, max cycles waiting for ctl_ready after GUARD before error; counter width clog2(TIMEOUT+1)
SKIP_LA, 1, 1 = omit LA0..LA3 when req_addr equals last successfully loaded address

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  issuer can accept request
req_write  in  1  1 = write page, 0 = read page
req_addr  in  32  page address; byte k goes to LAk (k=0 is addr[7:0])
req_data  in  32  write data; byte k goes to LDk
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  32  read data (ctl_page snapshot); 0 for writes and errors
rsp_error  out  1  qualifies rsp_valid; 1 = timeout
inst  out  12  {opcode[3:0], imm[7:0]} to DdrCtl1
inst_en  out  1  inst valid this cycle
ctl_page  in  32  DdrCtl1 page output
ctl_ready  in  1  DdrCtl1 ready

Behaviour:
- Opcode values are the DdrCtl1 encodings: NOP=0, LA0..LA3=1..4, LD0..LD3=5..8, RDP=9, WRP=A.
- Reset (reset=0, asynchronous):
  - state=IDLE; inst=0; inst_en=0; req_ready=0; rsp_valid=0; rsp_error=0; rsp_data=0.
  - addr_cached=0; counters=0.
- All outputs are registered.
- IDLE:
  - req_ready = ctl_ready (registered, so it trails ctl_ready by 1 cycle).
  - No request is accepted during controller power-up while ctl_ready=0.
  - Accept on req_valid && req_ready. On acceptance, latch write, addr, data and deassert req_ready.
- LOAD_A:
  - Skipped entirely if SKIP_LA=1, addr_cached=1 and the latched addr equals last_addr.
  - Otherwise, on 4 consecutive cycles: inst={LAk, addr byte k} for k=0..3, inst_en=1.
- LOAD_D (writes only): 4 cycles, inst={LDk, data byte k}, inst_en=1.
- ISSUE: 1 cycle, inst={WRP or RDP, 8'h00}, inst_en=1.
- GUARD: GUARD cycles, inst={NOP,0}, inst_en=0.
- WAIT:
  - inst_en=0. Count cycles while ctl_ready=0.
  - First cycle with ctl_ready=1 → RESP. rsp_data=ctl_page for reads, 0 for writes; rsp_error=0; last_addr=addr; addr_cached=1.
  - Count reaching TIMEOUT → RESP with rsp_error=1, rsp_data=0, addr_cached=0.
- RESP: rsp_valid=1 for exactly 1 cycle, then IDLE. rsp_* fields hold until the next RESP.
- First inst_en cycle is the cycle after the acceptance edge.
- Full write issue = 9 inst_en cycles (5 with skip). Full read issue = 5 (1 with skip).
- inst_en is never asserted outside LOAD_A, LOAD_D or ISSUE.
- req_valid while busy: req_ready=0 and the request is held by the requester; no queueing.
- ctl_ready dropping while IDLE with no acceptance: req_ready follows 1 cycle later. A request seen in the same cycle is accepted, which is safe because inst is only driven the next cycle.
- reset mid-sequence: instruction stream aborts immediately, no response is generated, addr_cached=0.

Test Plan:
- Power-up: ctl_ready=0 for 100 cycles then 1, req_valid held → req_ready=0 throughout the low period; acceptance on the 2nd cycle after ctl_ready rises.
- Write addr=0x002B3F12, data=0xDDCCBBAA → inst_en sequence 0x112,0x23F,0x32B,0x400,0x5AA,0x6BB,0x7CC,0x8DD,0xA00. Model drops ctl_ready, raises it 30 cycles later → one rsp_valid, rsp_error=0, rsp_data=0.
- Read same addr, SKIP_LA=1, model page=0xDDCCBBAA → only 0x900 issued; rsp_data=0xDDCCBBAA.
- Read addr=0x012B3F12 → LA0..LA3 reissued with LA3 imm 0x01, then 0x900.
- Timeout: after ISSUE, ctl_ready held 0 → rsp_valid with rsp_error=1 exactly GUARD+TIMEOUT cycles after ISSUE. The next request to the same addr reissues all LA instructions.
- Reset pulse at the LD1 cycle of a write → inst_en=0 asynchronously, no rsp_valid. The next write reissues the full 9-instruction sequence.
